// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl -- multi-cycle multiply/divide sequencer beside the single-cycle ALU.
// An iterative shift-add multiplier and a restoring divider share one set of
// working registers. A valid/ready handshake stalls the pipeline until the
// consumer takes the result.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   flush                 abort any in-flight op; wins over out_ready and in_valid
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   op[2:0]               0 MUL,1 MULW,2 DIVW,3 REMW,4 DIV,5 DIVU,6 REM,7 REMU
//   src1, src2            multiplicand/dividend, multiplier/divisor
//   out_valid / out_ready result handshake
//   result                registered result, stable while in DONE
//   busy                  high in CALC or DONE (pipeline stall)
//
// Build option: MDU_DIV0_BYPASS_EN -- divide by zero skips CALC and reaches DONE
// one cycle after acceptance. The result is the same either way.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one multiply/divide iteration per cycle, counter counts down from N
// DONE  | out_valid high, result held until out_ready

module mdu_seq_ctrl #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              is_mul, is_w, is_rem, neg_q, neg_r, div0;
   // Multiply: acc = product, opa = multiplicand (shifts left), opb = multiplier (shifts right).
   // Divide:   acc = partial remainder, opa = dividend/quotient shifter, opb = divisor.
   logic [XLEN-1:0]   acc, opa, opb;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   // Request decode, only consumed on the accept edge.
   logic              dec_mul, dec_w, dec_signed, dec_rem;
   logic              dec_sign1, dec_sign2, dec_div0, byp_hit;
   logic [XLEN-1:0]   dec_s1, dec_s2, dec_mag1, dec_mag2, dec_qinit, byp_res;

   always_comb begin
      dec_mul    = (op == 3'd0) || (op == 3'd1);
      dec_w      = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
      dec_signed = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd6);
      dec_rem    = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
      dec_s1     = dec_w ? sext32(src1[31:0]) : src1;
      dec_s2     = dec_w ? sext32(src2[31:0]) : src2;
      dec_sign1  = dec_signed && dec_s1[XLEN-1];
      dec_sign2  = dec_signed && dec_s2[XLEN-1];
      dec_mag1   = dec_sign1 ? -dec_s1 : dec_s1;
      dec_mag2   = dec_sign2 ? -dec_s2 : dec_s2;
      dec_div0   = (dec_s2 == '0);
      // W dividends sit in the top half so 32 iterations consume exactly their bits.
      dec_qinit  = dec_w ? (dec_mag1 << (XLEN-32)) : dec_mag1;
      byp_res    = dec_rem ? dec_s1 : '1;
   end

`ifdef MDU_DIV0_BYPASS_EN
   assign byp_hit = !dec_mul && dec_div0;
`else
   assign byp_hit = 1'b0;
`endif

   // One iteration step plus the final fixup applied on the last CALC cycle.
   logic [XLEN:0]     r_sh, r_sub;
   logic              r_ge;
   logic [XLEN-1:0]   acc_nx, opa_nx, opb_nx, quo, rem_v, fin_raw, fin_res;

   always_comb begin
      r_sh  = {acc, opa[XLEN-1]};
      r_sub = r_sh - {1'b0, opb};
      r_ge  = (r_sh >= {1'b0, opb});
      if (is_mul) begin
         acc_nx = acc + (opb[0] ? opa : '0);
         opa_nx = opa << 1;
         opb_nx = opb >> 1;
      end else begin
         acc_nx = r_ge ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0];
         opa_nx = {opa[XLEN-2:0], r_ge};
         opb_nx = opb;
      end
      // A zero divisor leaves the remainder equal to the dividend magnitude, so only
      // the quotient needs forcing; most-negative / -1 wraps to the right answer.
      quo     = div0 ? '1 : (neg_q ? -opa_nx : opa_nx);
      rem_v   = neg_r ? -acc_nx : acc_nx;
      fin_raw = is_mul ? acc_nx : (is_rem ? rem_v : quo);
      fin_res = is_w ? sext32(fin_raw[31:0]) : fin_raw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         is_mul    <= 1'b0;
         is_w      <= 1'b0;
         is_rem    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div0      <= 1'b0;
         acc       <= '0;
         opa       <= '0;
         opb       <= '0;
      end else if (flush) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  is_mul   <= dec_mul;
                  is_w     <= dec_w;
                  is_rem   <= dec_rem;
                  neg_q    <= dec_sign1 ^ dec_sign2;
                  neg_r    <= dec_sign1;
                  div0     <= dec_div0;
                  acc      <= '0;
                  opa      <= dec_mul ? src1 : dec_qinit;
                  opb      <= dec_mul ? src2 : dec_mag2;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (byp_hit) begin
                     state     <= S_DONE;
                     result    <= byp_res;
                     out_valid <= 1'b1;
                  end else begin
                     state <= S_CALC;
                     cnt   <= dec_w ? CNT_W'(32) : CNT_W'(XLEN);
                  end
               end
            end
            S_CALC: begin
               acc <= acc_nx;
               opa <= opa_nx;
               opb <= opb_nx;
               if (cnt == CNT_W'(1)) begin
                  state     <= S_DONE;
                  result    <= fin_res;
                  out_valid <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: directed vector table, randomized ops against a
// plain-arithmetic reference model, and hand sequences for flush/hold/reset.
module tb_mdu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]  op;
   logic [63:0] src1, src2, result;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MDU_DIV0_BYPASS_EN
   localparam int L64Z = 1;
   localparam int L32Z = 1;
`else
   localparam int L64Z = 65;
   localparam int L32Z = 33;
`endif

   mdu_seq_ctrl #(.XLEN(64), .CNT_W(7)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src1(src1), .src2(src2),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] w);
      return {{32{w[31]}}, w};
   endfunction

   // Reference: architectural results straight from signed/unsigned arithmetic.
   function automatic logic [63:0] ref_mdu(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
      longint sa, sb;
      int     wa, wb;
      logic [31:0] w;
      sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
      case (o)
         3'd0: return a * b;
         3'd1: begin w = a[31:0] * b[31:0]; return sx(w); end
         3'd2: begin
            if (wb == 0) w = '1;
            else if (wa == 32'sh8000_0000 && wb == -1) w = 32'(wa);
            else w = 32'(wa / wb);
            return sx(w);
         end
         3'd3: begin
            if (wb == 0) w = 32'(wa);
            else if (wa == 32'sh8000_0000 && wb == -1) w = '0;
            else w = 32'(wa % wb);
            return sx(w);
         end
         3'd4: begin
            if (sb == 0) return '1;
            if (sa == 64'sh8000_0000_0000_0000 && sb == -1) return a;
            return 64'(sa / sb);
         end
         3'd6: begin
            if (sb == 0) return a;
            if (sa == 64'sh8000_0000_0000_0000 && sb == -1) return '0;
            return 64'(sa % sb);
         end
         3'd5: return (b == 0) ? '1 : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [63:0] b);
      bit isw, z;
      isw = (o == 3'd1) || (o == 3'd2) || (o == 3'd3);
      z   = (o >= 3'd2) && (isw ? (b[31:0] == 32'd0) : (b == 64'd0));
`ifdef MDU_DIV0_BYPASS_EN
      if (z) return 1;
`else
      if (z) return isw ? 33 : 65;
`endif
      return isw ? 33 : 65;
   endfunction

   // Latency counts the accept edge as cycle 1; out_valid sampled 1 unit after each edge.
   task automatic do_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
      op = o; src1 = a; src2 = b; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; lat = 1;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      r = result;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[20];

   initial begin
      logic [63:0] r, a, b, e;
      logic [2:0]  o;
      int          lat, seen;

      vecs[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
      vecs[1]  = '{3'd1, 64'h0000_0000_8000_0000, 64'd2, 64'd0, 33};
      vecs[2]  = '{3'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
      vecs[3]  = '{3'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
      vecs[4]  = '{3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65};
      vecs[5]  = '{3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
      vecs[6]  = '{3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, L64Z};
      vecs[7]  = '{3'd7, 64'd5, 64'd0, 64'd5, L64Z};
      vecs[8]  = '{3'd2, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, L32Z};
      vecs[9]  = '{3'd3, 64'd5, 64'h0000_0001_0000_0000, 64'd5, L32Z};
      vecs[10] = '{3'd6, 64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF7, L64Z};
      vecs[11] = '{3'd4, 64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, L64Z};
      vecs[12] = '{3'd2, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 33};
      vecs[13] = '{3'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 33};
      vecs[14] = '{3'd5, 64'd100, 64'd7, 64'd14, 65};
      vecs[15] = '{3'd7, 64'd100, 64'd7, 64'd2, 65};
      vecs[16] = '{3'd1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd1, 33};
      vecs[17] = '{3'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
      vecs[18] = '{3'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65};
      vecs[19] = '{3'd0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0, 65};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; src1 = '0; src2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", result, 64'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
         check($sformatf("vec%0d_result", i), r, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      end

      for (int k = 0; k < 40; k++) begin
         o = 3'($urandom_range(0, 7));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = {$urandom, 32'h0};
            2: begin
               a = ((o == 3'd2) || (o == 3'd3)) ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
               b = '1;
            end
            3: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 20)); end
            4: begin a = -64'($urandom_range(0, 1000)); b = -64'($urandom_range(1, 20)); end
            default: ;
         endcase
         e = ref_mdu(o, a, b);
         do_op(o, a, b, r, lat);
         check($sformatf("rnd%0d_op%0d_result", k, o), r, e);
         check($sformatf("rnd%0d_op%0d_latency", k, o), 64'(lat), 64'(ref_lat(o, b)));
      end

      // Flush during CALC.
      @(negedge clk); op = 3'd4; src1 = 64'd1000; src2 = 64'd7; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      check("calc_busy", 64'(busy), 64'd1);
      check("calc_in_ready", 64'(in_ready), 64'd0);
      repeat (9) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      seen = 0;
      repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
      check("flush_no_valid_after", 64'(seen), 64'd0);

      // Flush beats in_valid in IDLE.
      @(negedge clk); flush = 1'b1; op = 3'd0; src1 = 64'd2; src2 = 64'd3; in_valid = 1'b1;
      @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
      check("idle_flush_busy", 64'(busy), 64'd0);
      check("idle_flush_in_ready", 64'(in_ready), 64'd1);

      // in_valid while busy is ignored; then hold out_ready low in DONE.
      @(negedge clk); op = 3'd0; src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1;
      @(posedge clk); #1; lat = 1;
      @(negedge clk); op = 3'd0; src1 = 64'd100; src2 = 64'd100; in_valid = 1'b1;
      @(posedge clk); #1; lat++;
      check("busy_in_ready", 64'(in_ready), 64'd0);
      check("busy_busy", 64'(busy), 64'd1);
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      check("hold_latency", 64'(lat), 64'd65);
      @(negedge clk); in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d_out_valid", c), 64'(out_valid), 64'd1);
         check($sformatf("hold%0d_result", c), result, 64'd15);
      end
      // Flush beats out_ready in DONE.
      @(negedge clk); flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
      check("done_flush_out_valid", 64'(out_valid), 64'd0);
      check("done_flush_in_ready", 64'(in_ready), 64'd1);
      check("done_flush_busy", 64'(busy), 64'd0);

      // Reset in CALC.
      @(negedge clk); op = 3'd0; src1 = 64'd123; src2 = 64'd456; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_result", result, 64'd0);
      @(negedge clk); rst = 1'b0;
      do_op(3'd5, 64'd100, 64'd7, r, lat);
      check("post_rst_result", r, 64'd14);
      check("post_rst_latency", 64'(lat), 64'd65);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
